uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled by the system clock.
// Good frames update uart_data with a one-cycle ready strobe; bad stop bits pulse uart_frame_error.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 347
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_data_ready,
  output logic       uart_frame_error
);

  localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state, state_nxt;
  logic        rx_s1, rx_s;
  logic [15:0] clk_cnt, cnt_nxt;
  logic [2:0]  bit_idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_nxt;
  logic        ready_nxt, err_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1            <= 1'b1;
      rx_s             <= 1'b1;
      state            <= IDLE;
      clk_cnt          <= '0;
      bit_idx          <= '0;
      shift            <= '0;
      uart_data        <= '0;
      uart_data_ready  <= 1'b0;
      uart_frame_error <= 1'b0;
    end else begin
      rx_s1            <= uart_rxd;
      rx_s             <= rx_s1;
      state            <= state_nxt;
      clk_cnt          <= cnt_nxt;
      bit_idx          <= idx_nxt;
      shift            <= shift_nxt;
      uart_data        <= data_nxt;
      uart_data_ready  <= ready_nxt;
      uart_frame_error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = uart_data;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects short low glitches on the idle line.
        if (clk_cnt == HALF_CNT) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = clk_cnt + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = clk_cnt + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = clk_cnt + 16'd1;
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line recovers so a break yields a single error.
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against uart_rx at 16 clocks per bit.
// Expected bytes and strobe times come from the frame contents and the latency formula.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HB   = (CPB - 1) / 2;
  localparam int unsigned LAT  = 2 + HB + 9 * CPB + 2;
  localparam int unsigned NRND = 24;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_data_ready;
  logic       uart_frame_error;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned both_cnt = 0;
  int unsigned wide_cnt = 0;
  logic        prev_rdy = 1'b0;

  logic [7:0]  rdy_d[$];
  int unsigned rdy_t[$];
  int unsigned err_t[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock           (clock),
    .reset           (reset),
    .uart_rxd        (uart_rxd),
    .uart_data       (uart_data),
    .uart_data_ready (uart_data_ready),
    .uart_frame_error(uart_frame_error)
  );

  always #12.5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (uart_data_ready) begin
      rdy_d.push_back(uart_data);
      rdy_t.push_back(cyc);
    end
    if (uart_frame_error) err_t.push_back(cyc);
    if (uart_data_ready && uart_frame_error) both_cnt++;
    if (uart_data_ready && prev_rdy) wide_cnt++;
    prev_rdy = uart_data_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic near(input int unsigned d, input int unsigned want);
    return (d + 1 >= want) && (d <= want + 1);
  endfunction

  task automatic idle(input int unsigned n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic clear_q();
    rdy_d.delete();
    rdy_t.delete();
    err_t.delete();
  endtask

  task automatic expect_one(input string tag, input logic [7:0] b, input int unsigned t0);
    check({tag, "_rdy_cnt"}, rdy_d.size(), 1);
    check({tag, "_err_cnt"}, err_t.size(), 0);
    if (rdy_d.size() >= 1) begin
      check({tag, "_data"}, rdy_d[0], b);
      check({tag, "_lat"}, near(rdy_t[0] - t0, LAT), 1);
    end
  endtask

  initial begin
    int unsigned t0, t1;
    logic [7:0]  exp_b[$];
    int unsigned exp_t[$];

    // Reset and idle line
    reset = 1'b1;
    uart_rxd = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    clear_q();
    check("rst_data", uart_data, 8'h00);
    check("rst_rdy", uart_data_ready, 1'b0);
    check("rst_err", uart_frame_error, 1'b0);
    idle(100);
    check("idle_rdy_cnt", rdy_d.size(), 0);
    check("idle_err_cnt", err_t.size(), 0);
    check("idle_data", uart_data, 8'h00);

    // Single frame 0xAC
    clear_q();
    send_frame(8'hAC, 1'b1, t0);
    idle(2 * CPB);
    expect_one("ac", 8'hAC, t0);
    idle(50);
    check("ac_hold", uart_data, 8'hAC);

    // Back-to-back frames, no idle gap
    clear_q();
    send_frame(8'hAD, 1'b1, t0);
    send_frame(8'hAE, 1'b1, t1);
    idle(2 * CPB);
    check("b2b_rdy_cnt", rdy_d.size(), 2);
    check("b2b_err_cnt", err_t.size(), 0);
    if (rdy_d.size() >= 2) begin
      check("b2b_d0", rdy_d[0], 8'hAD);
      check("b2b_d1", rdy_d[1], 8'hAE);
      check("b2b_gap", near(rdy_t[1] - rdy_t[0], 10 * CPB), 1);
      check("b2b_lat", near(rdy_t[1] - t1, LAT), 1);
    end

    // Short low glitch, then a real frame
    clear_q();
    uart_rxd = 1'b0;
    repeat (4) @(negedge clock);
    idle(3 * CPB);
    check("glitch_rdy_cnt", rdy_d.size(), 0);
    check("glitch_err_cnt", err_t.size(), 0);
    send_frame(8'h55, 1'b1, t0);
    idle(2 * CPB);
    expect_one("g55", 8'h55, t0);

    // Bad stop bit, then recovery
    clear_q();
    send_frame(8'h3C, 1'b0, t0);
    idle(3 * CPB);
    check("ferr_err_cnt", err_t.size(), 1);
    check("ferr_rdy_cnt", rdy_d.size(), 0);
    check("ferr_data", uart_data, 8'h55);
    clear_q();
    send_frame(8'hC3, 1'b1, t0);
    idle(2 * CPB);
    expect_one("c3", 8'hC3, t0);

    // Break: 20 bit periods low
    clear_q();
    uart_rxd = 1'b0;
    repeat (20 * CPB) @(negedge clock);
    idle(3 * CPB);
    check("brk_err_cnt", err_t.size(), 1);
    check("brk_rdy_cnt", rdy_d.size(), 0);

    // Reset in the middle of frame 0xFF
    clear_q();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    check("mrst_data", uart_data, 8'h00);
    idle(10 * CPB);
    check("mrst_rdy_cnt", rdy_d.size(), 0);
    check("mrst_err_cnt", err_t.size(), 0);
    check("mrst_data2", uart_data, 8'h00);
    clear_q();
    send_frame(8'h81, 1'b1, t0);
    idle(2 * CPB);
    expect_one("m81", 8'h81, t0);

    // Randomized bytes with random inter-frame gaps
    clear_q();
    for (int n = 0; n < NRND; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_b.push_back(b);
      send_frame(b, 1'b1, t0);
      exp_t.push_back(t0);
      idle($urandom_range(0, 2) * CPB + $urandom_range(0, 5));
    end
    idle(2 * CPB);
    check("rnd_rdy_cnt", rdy_d.size(), NRND);
    check("rnd_err_cnt", err_t.size(), 0);
    for (int n = 0; n < NRND; n++) begin
      if (n < rdy_d.size()) begin
        check($sformatf("rnd_data_%0d", n), rdy_d[n], exp_b[n]);
        check($sformatf("rnd_lat_%0d", n), near(rdy_t[n] - exp_t[n], LAT), 1);
      end
    end

    check("pulse_overlap", both_cnt, 0);
    check("pulse_width", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
